c16_mmio_ctrl: RTL and testbench

Memory-mapped I/O controller for the c16 CPU's upper address half (0x8000–0xFFFF). It accepts single-word load/store requests from the core and buffers stores in a small write FIFO. The FIFO drains one store per cycle onto the shared sound/video write port (`snd_wen`/`vid_wen`, `w_param`, `w_index`, `w_val`). The block also serves key/switch reads and generates the core's `int_trig` from debounced-free key-press edges under a software mask.

---
 rtl/c16_mmio_pkg.sv | 45 ++++
 rtl/c16_mmio_fifo.sv | 62 ++++++
 rtl/c16_mmio_ctrl.sv | 168 ++++++++++++++++
 tb/tb_c16_mmio_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/c16_mmio_pkg.sv
// Shared types and constants for the c16 upper-half MMIO controller.
// The region map, input-block offsets and write-FIFO entry layout are defined here.
package c16_mmio_pkg;

  localparam logic [1:0] RGN_VID = 2'b00;
  localparam logic [1:0] RGN_SND = 2'b01;
  localparam logic [1:0] RGN_IN  = 2'b10;
  localparam logic [1:0] RGN_RSV = 2'b11;

  localparam logic [1:0] IN_KEY  = 2'd0;
  localparam logic [1:0] IN_SW   = 2'd1;
  localparam logic [1:0] IN_PEND = 2'd2;
  localparam logic [1:0] IN_MASK = 2'd3;

  typedef enum logic {
    TGT_VID = 1'b0,
    TGT_SND = 1'b1
  } tgt_e;

  typedef struct packed {
    tgt_e        target;
    logic [1:0]  param;
    logic [10:0] index;
    logic [15:0] val;
  } wr_entry_t;

  localparam int ENTRY_W = $bits(wr_entry_t);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } req_state_e;

  // Splits a video/sound word address into its write-port fields.
  function automatic wr_entry_t make_entry(input logic [15:0] addr,
                                           input logic [15:0] data);
    wr_entry_t e;
    e.target = (addr[14:13] == RGN_SND) ? TGT_SND : TGT_VID;
    e.param  = addr[12:11];
    e.index  = addr[10:0];
    e.val    = data;
    return e;
  endfunction

endpackage

// File: rtl/c16_mmio_fifo.sv
// Synchronous FIFO with extra-MSB pointers (full = MSBs differ, rest equal).
// The head entry is visible combinationally whenever the FIFO is non-empty.
module c16_mmio_fifo
  import c16_mmio_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // A push while full is refused even if a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: the storage array is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  assign head = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/c16_mmio_ctrl.sv
// c16 MMIO controller for 0x8000-0xFFFF: request FSM, region decode, buffered
// video/sound stores, key/switch reads and the masked key-press interrupt.
module c16_mmio_ctrl
  import c16_mmio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int KEY_W      = 4,
  parameter int SW_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [15:0]       req_addr,
  input  logic [15:0]       req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [15:0]       rsp_rdata,
  input  logic [KEY_W-1:0]  key,
  input  logic [SW_W-1:0]   sw,
  output logic              snd_wen,
  output logic              vid_wen,
  output logic [1:0]        w_param,
  output logic [10:0]       w_index,
  output logic [15:0]       w_val,
  output logic              int_trig,
  input  logic              int_ack
);

  req_state_e        state_q, state_d;
  logic [KEY_W-1:0]  key_s1_q, key_s1_d;
  logic [KEY_W-1:0]  key_s2_q, key_s2_d;
  logic [KEY_W-1:0]  key_prev_q, key_prev_d;
  logic [SW_W-1:0]   sw_s1_q, sw_s1_d;
  logic [SW_W-1:0]   sw_s2_q, sw_s2_d;
  logic [KEY_W-1:0]  pending_q, pending_d;
  logic [KEY_W-1:0]  mask_q, mask_d;
  logic              int_trig_q, int_trig_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;

  logic [1:0]        rgn;
  logic [1:0]        in_off;
  logic              accept;
  logic              acc_load;
  logic              acc_store;
  logic              fifo_push;
  logic              fifo_full;
  logic              fifo_empty;
  logic              drain;
  wr_entry_t         push_entry;
  logic [ENTRY_W-1:0] head_bits;
  wr_entry_t         head_entry;
  logic [KEY_W-1:0]  key_state;
  logic [KEY_W-1:0]  key_edge;
  logic              pend_clear;
  logic [15:0]       load_data;
  logic              unused_addr_msb;

  assign unused_addr_msb = req_addr[15];

  assign rgn       = req_addr[14:13];
  assign in_off    = req_addr[1:0];
  assign req_ready = (state_q == S_IDLE) && !fifo_full && !reset;
  assign accept    = req_valid && req_ready;
  assign acc_load  = accept && !req_we;
  assign acc_store = accept && req_we;

  assign fifo_push  = acc_store && ((rgn == RGN_VID) || (rgn == RGN_SND));
  assign push_entry = make_entry(req_addr, req_wdata);

  c16_mmio_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (!fifo_empty),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The head entry is popped the cycle it is presented, so each strobe lasts one cycle.
  assign head_entry = wr_entry_t'(head_bits);
  assign drain      = !fifo_empty && !reset;
  assign vid_wen    = drain && (head_entry.target == TGT_VID);
  assign snd_wen    = drain && (head_entry.target == TGT_SND);
  assign w_param    = drain ? head_entry.param : '0;
  assign w_index    = drain ? head_entry.index : '0;
  assign w_val      = drain ? head_entry.val   : '0;

  assign key_state  = ~key_s2_q;
  assign key_edge   = key_prev_q & ~key_s2_q;
  assign pend_clear = int_ack ||
                      (acc_load && (rgn == RGN_IN) && (in_off == IN_PEND));

  always_comb begin
    load_data = '0;
    if (rgn == RGN_IN) begin
      case (in_off)
        IN_KEY:  load_data = 16'(key_state);
        IN_SW:   load_data = 16'(sw_s2_q);
        IN_PEND: load_data = 16'(pending_q);
        IN_MASK: load_data = 16'(mask_q);
        default: load_data = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    key_s1_d    = key;
    key_s2_d    = key_s1_q;
    key_prev_d  = key_s2_q;
    sw_s1_d     = sw;
    sw_s2_d     = sw_s1_q;
    mask_d      = mask_q;
    rsp_rdata_d = '0;

    case (state_q)
      S_IDLE:  if (acc_load) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (acc_load) rsp_rdata_d = load_data;

    if (acc_store && (rgn == RGN_IN) && (in_off == IN_MASK))
      mask_d = req_wdata[KEY_W-1:0];

    // A press edge arriving with a clear wins for its own bit.
    pending_d  = (pending_q & ~{KEY_W{pend_clear}}) | key_edge;
    int_trig_d = |(pending_d & mask_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      key_s1_q    <= '1;
      key_s2_q    <= '1;
      key_prev_q  <= '1;
      sw_s1_q     <= '1;
      sw_s2_q     <= '1;
      pending_q   <= '0;
      mask_q      <= '0;
      int_trig_q  <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      key_s1_q    <= key_s1_d;
      key_s2_q    <= key_s2_d;
      key_prev_q  <= key_prev_d;
      sw_s1_q     <= sw_s1_d;
      sw_s2_q     <= sw_s2_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      int_trig_q  <= int_trig_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign int_trig  = int_trig_q;

endmodule

// File: tb/tb_c16_mmio_ctrl.sv
// Self-checking bench for c16_mmio_ctrl: a request table plus hand-written
// sequences, with write and load-response scoreboards checked by a monitor.
module tb_c16_mmio_ctrl;

  localparam int FIFO_DEPTH = 4;
  localparam int KEY_W      = 4;
  localparam int SW_W       = 10;
  localparam int K_NONE     = 0;
  localparam int K_VID      = 1;
  localparam int K_SND      = 2;

  logic              clk;
  logic              reset;
  logic              req_valid;
  logic              req_we;
  logic [15:0]       req_addr;
  logic [15:0]       req_wdata;
  logic              req_ready;
  logic              rsp_valid;
  logic [15:0]       rsp_rdata;
  logic [KEY_W-1:0]  key;
  logic [SW_W-1:0]   sw;
  logic              snd_wen;
  logic              vid_wen;
  logic [1:0]        w_param;
  logic [10:0]       w_index;
  logic [15:0]       w_val;
  logic              int_trig;
  logic              int_ack;

  c16_mmio_ctrl #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .KEY_W      (KEY_W),
    .SW_W       (SW_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .key       (key),
    .sw        (sw),
    .snd_wen   (snd_wen),
    .vid_wen   (vid_wen),
    .w_param   (w_param),
    .w_index   (w_index),
    .w_val     (w_val),
    .int_trig  (int_trig),
    .int_ack   (int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        snd;
    logic [1:0]  p;
    logic [10:0] i;
    logic [15:0] v;
  } wr_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          kind;
    logic [1:0]  p;
    logic [10:0] idx;
    logic [15:0] rd;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  wr_t         wr_q[$];
  logic [15:0] rd_q[$];
  int          strobe_cyc[$];
  wr_t         mon_e;
  logic [15:0] mon_rd;
  vec_t        vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string why);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, why, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: strobes pop the write queue, responses pop the load queue.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check("one_strobe", 32'(snd_wen & vid_wen), 32'd0);
      if (snd_wen || vid_wen) begin
        strobe_cyc.push_back(cyc);
        if (wr_q.size() == 0) begin
          fail_now("strobe_expected", "write strobe with no store outstanding");
        end else begin
          mon_e = wr_q.pop_front();
          check("w_target", 32'(snd_wen), 32'(mon_e.snd));
          check("w_param",  32'(w_param), 32'(mon_e.p));
          check("w_index",  32'(w_index), 32'(mon_e.i));
          check("w_val",    32'(w_val),   32'(mon_e.v));
        end
      end else begin
        check("idle_payload", 32'({w_param, w_index, w_val}), 32'd0);
      end
      if (rsp_valid) begin
        check("rsp_ready_low", 32'(req_ready), 32'd0);
        if (rd_q.size() == 0) begin
          fail_now("rsp_expected", "rsp_valid with no load outstanding");
        end else begin
          mon_rd = rd_q.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(mon_rd));
        end
      end else begin
        check("idle_rdata", 32'(rsp_rdata), 32'd0);
      end
    end
  end

  task automatic idle();
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                        input int kind, input logic [1:0] p, input logic [10:0] idx,
                        input logic [15:0] rd);
    int   n;
    logic acc;
    wr_t  e;
    n   = 0;
    acc = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (!acc && n < 20) begin
      @(negedge clk);
      if (req_ready) acc = 1'b1;
      else n++;
    end
    if (!acc) begin
      fail_now("req_accept", $sformatf("request 0x%0h never accepted", addr));
      idle();
      tick(1);
      return;
    end
    if (we && kind != K_NONE) begin
      e.snd = (kind == K_SND);
      e.p   = p;
      e.i   = idx;
      e.v   = wdata;
      wr_q.push_back(e);
    end
    if (!we) rd_q.push_back(rd);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs.push_back('{1'b1, 16'h9FFF, 16'hBEEF, K_VID,  2'd3, 11'h7FF, 16'h0000});
    vecs.push_back('{1'b1, 16'hA7FF, 16'h0042, K_SND,  2'd0, 11'h7FF, 16'h0000});
    vecs.push_back('{1'b1, 16'hB801, 16'h0055, K_SND,  2'd3, 11'h001, 16'h0000});
    vecs.push_back('{1'b1, 16'hE123, 16'hFFFF, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b0, 16'hE000, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b0, 16'h8005, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b0, 16'hA000, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b0, 16'hC001, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h02A5});
    vecs.push_back('{1'b0, 16'hC000, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b1, 16'hC003, 16'h000A, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b0, 16'hC003, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h000A});
    vecs.push_back('{1'b0, 16'hDFFF, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h000A});
    vecs.push_back('{1'b1, 16'hC000, 16'hFFFF, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b0, 16'hC003, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h000A});
    vecs.push_back('{1'b1, 16'hC003, 16'hFFF5, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b0, 16'hC003, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h0005});
    vecs.push_back('{1'b1, 16'hC003, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b0, 16'hC002, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b1, 16'hC001, 16'h1234, K_NONE, 2'd0, 11'h000, 16'h0000});
    vecs.push_back('{1'b0, 16'hC001, 16'h0000, K_NONE, 2'd0, 11'h000, 16'h02A5});

    reset   = 1'b1;
    key     = '1;
    sw      = 10'h2A5;
    int_ack = 1'b0;
    idle();

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_strobes",   32'({snd_wen, vid_wen}), 32'd0);
    check("reset_payload",   32'({w_param, w_index, w_val}), 32'd0);
    check("reset_int_trig",  32'(int_trig), 32'd0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 32'(req_ready), 32'd1);
    tick(1);

    // Single video store: strobe in the cycle right after acceptance, exactly once.
    do_req(1'b1, 16'h8005, 16'h1234, K_VID, 2'd0, 11'd5, 16'h0);
    idle();
    @(negedge clk);
    check("vid_lat_wen",   32'(vid_wen), 32'd1);
    check("vid_lat_snd",   32'(snd_wen), 32'd0);
    check("vid_lat_param", 32'(w_param), 32'd0);
    check("vid_lat_index", 32'(w_index), 32'd5);
    check("vid_lat_val",   32'(w_val),   32'h1234);
    @(negedge clk);
    check("vid_one_pulse", 32'(vid_wen), 32'd0);
    tick(1);

    for (int k = 0; k < vecs.size(); k++) begin
      do_req(vecs[k].we, vecs[k].addr, vecs[k].wdata, vecs[k].kind,
             vecs[k].p, vecs[k].idx, vecs[k].rd);
      idle();
    end
    tick(4);
    check("table_int_trig", 32'(int_trig), 32'd0);

    // Back-to-back sound stores drain in order on consecutive cycles.
    strobe_cyc.delete();
    for (int d = 1; d <= 5; d++)
      do_req(1'b1, 16'hA7FF, 16'(d), K_SND, 2'd0, 11'h7FF, 16'h0);
    idle();
    tick(8);
    check("burst_count", 32'(strobe_cyc.size()), 32'd5);
    for (int k = 1; k < strobe_cyc.size(); k++)
      check("burst_consecutive", 32'(strobe_cyc[k] - strobe_cyc[k-1]), 32'd1);

    // Masked key press: int_trig after three edges, cleared by reading pending.
    do_req(1'b1, 16'hC003, 16'h0001, K_NONE, 2'd0, 11'd0, 16'h0);
    idle();
    tick(2);
    key[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("trig_latency", 32'(int_trig), (k == 3) ? 32'd1 : 32'd0);
    end
    @(posedge clk);
    #1;
    do_req(1'b0, 16'hC002, 16'h0, K_NONE, 2'd0, 11'd0, 16'h0001);
    idle();
    @(negedge clk);
    check("trig_clear_on_read", 32'(int_trig), 32'd0);
    key[0] = 1'b1;
    tick(1);

    // Unmasked key press records pending but never triggers.
    key[1] = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("trig_masked_off", 32'(int_trig), 32'd0);
    end
    @(posedge clk);
    #1;
    do_req(1'b0, 16'hC000, 16'h0, K_NONE, 2'd0, 11'd0, 16'h0002);
    do_req(1'b0, 16'hC002, 16'h0, K_NONE, 2'd0, 11'd0, 16'h0002);
    idle();
    key[1] = 1'b1;
    tick(2);

    // int_ack coinciding with a new key[2] edge: bit 2 survives, older bit 3 clears.
    key[3] = 1'b0;
    tick(4);
    key[2] = 1'b0;
    tick(2);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    do_req(1'b0, 16'hC002, 16'h0, K_NONE, 2'd0, 11'd0, 16'h0004);
    idle();
    key = '1;
    tick(2);
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
    do_req(1'b0, 16'hC002, 16'h0, K_NONE, 2'd0, 11'd0, 16'h0000);
    idle();
    tick(2);

    // Reset mid-drain flushes the FIFO.
    do_req(1'b1, 16'h8001, 16'h0011, K_VID, 2'd0, 11'd1, 16'h0);
    do_req(1'b1, 16'h8002, 16'h0022, K_VID, 2'd0, 11'd2, 16'h0);
    do_req(1'b1, 16'h8003, 16'h0033, K_VID, 2'd0, 11'd3, 16'h0);
    idle();
    reset = 1'b1;
    wr_q.delete();
    @(negedge clk);
    check("rst_mid_ready",   32'(req_ready), 32'd0);
    check("rst_mid_strobes", 32'({snd_wen, vid_wen}), 32'd0);
    check("rst_mid_payload", 32'({w_param, w_index, w_val}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    strobe_cyc.delete();
    @(negedge clk);
    check("rst_post_ready",   32'(req_ready), 32'd1);
    check("rst_post_rsp",     32'({rsp_valid, rsp_rdata}), 32'd0);
    check("rst_post_strobes", 32'({snd_wen, vid_wen}), 32'd0);
    check("rst_post_trig",    32'(int_trig), 32'd0);
    tick(1);
    do_req(1'b0, 16'hC003, 16'h0, K_NONE, 2'd0, 11'd0, 16'h0000);
    idle();
    tick(6);
    check("rst_no_strobes", 32'(strobe_cyc.size()), 32'd0);

    check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(rd_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
